// File: rtl/unary_add_pkg.sv
// Shared types and helpers for the unary adder driver: FSM state encoding and
// read-window sizing.
package unary_add_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Read window must cover the longest possible unary result plus settling slack.
  function automatic int unsigned rd_cycles(input int unsigned width, input int unsigned extra);
    return (32'd1 << width) - 32'd1 + extra;
  endfunction

endpackage

// File: rtl/unary_pulse_counter.sv
// Decodes the adder's unary dout stream: saturating pulse counter plus a sticky
// OR of the adder overflow flag. Next-state values are exported so the owner can
// capture the final count in the same edge as the last sampled pulse.
module unary_pulse_counter import unary_add_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             flag_in,
  output logic [WIDTH-1:0] count_next,
  output logic             flag_next
);

  logic [WIDTH-1:0] count_r;
  logic             flag_r;
  logic             sat_s;

  // Next count (saturating) and next sticky overflow flag.
  always_comb begin
    sat_s      = (count_r == '1);
    count_next = count_r;
    flag_next  = flag_r;
    if (clr) begin
      count_next = '0;
      flag_next  = 1'b0;
    end else begin
      if (inc && !sat_s) begin
        count_next = count_r + WIDTH'(1);
      end else begin
        count_next = count_r;
      end
      flag_next = flag_r | flag_in;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      flag_r  <= 1'b0;
    end else begin
      count_r <= count_next;
      flag_r  <= flag_next;
    end
  end

endmodule

// File: rtl/unary_add_driver.sv
// Host-side driver for the unary adder: serialises two binary operands into unary
// pulse trains on A/B, then reads the adder's unary sum back into binary with carry.
module unary_add_driver #(
  parameter int WIDTH    = unary_add_pkg::DEF_WIDTH,
  parameter int GAP      = 1,
  parameter int RD_EXTRA = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  input  logic             dout,
  input  logic             C
);
  import unary_add_pkg::*;

  localparam int RD_CYC = int'(rd_cycles(WIDTH, RD_EXTRA));
  localparam int RDW    = $clog2(RD_CYC + 1);
  localparam int GW     = (GAP > 1) ? $clog2(GAP + 1) : 1;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] rem_a_r, rem_a_s;
  logic [WIDTH-1:0] rem_b_r, rem_b_s;
  logic [WIDTH-1:0] slots_r, slots_s;
  logic [GW-1:0]    gap_r, gap_s;
  logic [RDW-1:0]   rd_r, rd_s;
  logic             a_s, b_s, en_s, rw_s, busy_s, done_s, carry_s;
  logic [WIDTH-1:0] result_s;
  logic             clr_s, inc_s, c_in_s;
  logic [WIDTH-1:0] cnt_next;
  logic             flag_next;

  // Counter controls: clear on accept, sample dout and C only inside the read window.
  always_comb begin
    clr_s  = (state_r == IDLE) && start;
    inc_s  = (state_r == READ) && dout;
    c_in_s = (state_r == READ) && C;
  end

  unary_pulse_counter #(.WIDTH(WIDTH)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_s),
    .inc        (inc_s),
    .flag_in    (c_in_s),
    .count_next (cnt_next),
    .flag_next  (flag_next)
  );

  // Next state first, then outputs and counter loads derived from the state being entered,
  // so every output is a register that lines up with its state.
  always_comb begin
    state_s  = state_r;
    rem_a_s  = rem_a_r;
    rem_b_s  = rem_b_r;
    slots_s  = slots_r;
    gap_s    = gap_r;
    rd_s     = rd_r;
    a_s      = 1'b0;
    b_s      = 1'b0;
    en_s     = 1'b0;
    rw_s     = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    result_s = result;
    carry_s  = carry;

    case (state_r)
      IDLE: begin
        if (start) begin
          rem_a_s = a_val;
          rem_b_s = b_val;
          slots_s = (a_val > b_val) ? a_val : b_val;
          if (slots_s == '0) begin
            state_s = READ;
          end else begin
            state_s = PULSE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PULSE: state_s = unary_add_pkg::GAP;
      unary_add_pkg::GAP: begin
        if (gap_r != '0) begin
          gap_s = gap_r - GW'(1);
        end else if (slots_r != '0) begin
          state_s = PULSE;
        end else begin
          state_s = READ;
        end
      end
      READ: begin
        if (rd_r == '0) begin
          state_s = DONE;
        end else begin
          rd_s = rd_r - RDW'(1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    case (state_s)
      PULSE: begin
        en_s    = 1'b1;
        busy_s  = 1'b1;
        a_s     = (rem_a_s != '0);
        b_s     = (rem_b_s != '0);
        rem_a_s = rem_a_s - WIDTH'(a_s);
        rem_b_s = rem_b_s - WIDTH'(b_s);
        slots_s = slots_s - WIDTH'(1);
      end
      unary_add_pkg::GAP: begin
        en_s   = 1'b1;
        busy_s = 1'b1;
        if (state_r != unary_add_pkg::GAP) begin
          gap_s = GW'(GAP - 1);
        end else begin
          gap_s = gap_s;
        end
      end
      READ: begin
        en_s   = 1'b1;
        rw_s   = 1'b1;
        busy_s = 1'b1;
        if (state_r != READ) begin
          rd_s = RDW'(RD_CYC - 1);
        end else begin
          rd_s = rd_s;
        end
      end
      DONE: begin
        busy_s   = 1'b1;
        done_s   = 1'b1;
        result_s = cnt_next;
        carry_s  = flag_next;
      end
      IDLE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      rem_a_r       <= '0;
      rem_b_r       <= '0;
      slots_r       <= '0;
      gap_r         <= '0;
      rd_r          <= '0;
      A             <= 1'b0;
      B             <= 1'b0;
      en            <= 1'b0;
      read_or_write <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      carry         <= 1'b0;
    end else begin
      state_r       <= state_s;
      rem_a_r       <= rem_a_s;
      rem_b_r       <= rem_b_s;
      slots_r       <= slots_s;
      gap_r         <= gap_s;
      rd_r          <= rd_s;
      A             <= a_s;
      B             <= b_s;
      en            <= en_s;
      read_or_write <= rw_s;
      busy          <= busy_s;
      done          <= done_s;
      result        <= result_s;
      carry         <= carry_s;
    end
  end

endmodule
